simd_exec_unit: RTL and testbench

Parametrised SIMD execute stage that supersedes the single-cycle per-lane ALU stage. Applies one lane-wise operation across VEC_SIZE lanes under a per-lane enable mask, supports an iterative multi-cycle multiply, registers its result behind a valid/ready handshake, maintains masked N/Z flags and resolves conditional PC writes. Sits between decode/register-read and writeback in the vector pipeline.

---
 rtl/simd_exec_unit_if.sv | 32 +++
 rtl/simd_exec_unit.sv | 164 ++++++++++++++++
 tb/tb_simd_exec_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/simd_exec_unit_if.sv
// Handshake and operand/result bundle between register-read, the SIMD execute
// stage and writeback. The master drives operations; the slave is the execute unit.
interface simd_exec_unit_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int VEC_SIZE      = 4
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [2:0]                              execute_op;
    logic [VEC_SIZE-1:0]                     lane_mask;
    logic                                    overwrite_flags;
    logic [2:0]                              pc_wr_en;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0]  vect1;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0]  vect2;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0]  vect_out;
    logic                                    pc_wr_en_out;
    logic [1:0]                              flags_nz;

    modport master (
        output in_valid, execute_op, lane_mask, overwrite_flags, pc_wr_en,
               vect1, vect2, out_ready,
        input  in_ready, out_valid, vect_out, pc_wr_en_out, flags_nz
    );

    modport slave (
        input  in_valid, execute_op, lane_mask, overwrite_flags, pc_wr_en,
               vect1, vect2, out_ready,
        output in_ready, out_valid, vect_out, pc_wr_en_out, flags_nz
    );
endinterface

// File: rtl/simd_exec_unit.sv
// Lane-wise SIMD execute stage: masked ALU ops, multi-cycle multiply, N/Z flag
// register and branch resolution, with a registered valid/ready result.
//
//   state  | meaning
//   S_IDLE | ready for a new op; non-MUL results load on the accepting edge
//   S_BUSY | multiply in flight, counting down to the result load
module simd_exec_unit #(
    parameter int REGISTER_SIZE = 32,
    parameter int VEC_SIZE      = 4,
    parameter int MUL_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    simd_exec_unit_if.slave    bus
);
    localparam int SH_W  = $clog2(REGISTER_SIZE);
    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e                                 r_state;
    logic [CNT_W-1:0]                       r_cnt;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] r_v1;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] r_v2;
    logic [VEC_SIZE-1:0]                    r_mask;
    logic                                   r_ovf;
    logic                                   r_br;
    logic                                   r_out_valid;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] r_vect_out;
    logic                                   r_pc_out;
    logic [1:0]                             r_flags;

    logic                                   w_in_ready;
    logic                                   w_accept;
    logic                                   w_busy;
    logic                                   w_load;
    logic                                   w_br_now;
    logic [2:0]                             w_src_op;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] w_src_v1;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] w_src_v2;
    logic [VEC_SIZE-1:0]                    w_src_mask;
    logic                                   w_src_ovf;
    logic                                   w_src_br;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] w_res;
    logic                                   w_n;
    logic                                   w_z;

    assign w_busy     = (r_state == S_BUSY);
    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Non-MUL ops go straight from the inputs to the output register; a MUL
    // finishes from the operands captured when it was accepted.
    assign w_src_op   = w_busy ? 3'(OP_MUL) : bus.execute_op;
    assign w_src_v1   = w_busy ? r_v1       : bus.vect1;
    assign w_src_v2   = w_busy ? r_v2       : bus.vect2;
    assign w_src_mask = w_busy ? r_mask     : bus.lane_mask;
    assign w_src_ovf  = w_busy ? r_ovf      : bus.overwrite_flags;
    assign w_src_br   = w_busy ? r_br       : w_br_now;

    assign w_load = (w_accept && (bus.execute_op != 3'(OP_MUL)))
                 || (w_busy && (r_cnt == '0));

    always_comb begin
        w_br_now = 1'b0;
        case (bus.pc_wr_en)
            3'b100:  w_br_now = ~r_flags[1];
            3'b010:  w_br_now = r_flags[1];
            3'b001:  w_br_now = r_flags[0];
            default: w_br_now = 1'b0;
        endcase
    end

    always_comb begin
        w_res = w_src_v1;
        for (int i = 0; i < VEC_SIZE; i++) begin
            case (w_src_op)
                3'(OP_ADD): w_res[i] = w_src_v1[i] + w_src_v2[i];
                3'(OP_SUB): w_res[i] = w_src_v1[i] - w_src_v2[i];
                3'(OP_AND): w_res[i] = w_src_v1[i] & w_src_v2[i];
                3'(OP_OR):  w_res[i] = w_src_v1[i] | w_src_v2[i];
                3'(OP_XOR): w_res[i] = w_src_v1[i] ^ w_src_v2[i];
                3'(OP_SLL): w_res[i] = w_src_v1[i] << w_src_v2[i][SH_W-1:0];
                3'(OP_SRL): w_res[i] = w_src_v1[i] >> w_src_v2[i][SH_W-1:0];
                default:    w_res[i] = w_src_v1[i] * w_src_v2[i];
            endcase
            if (!w_src_mask[i]) w_res[i] = w_src_v1[i];
        end
    end

    // Disabled lanes drop out of both reductions, so an empty mask gives N=0, Z=1.
    always_comb begin
        w_n = 1'b0;
        w_z = 1'b1;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (w_src_mask[i]) begin
                w_n = w_n | w_res[i][REGISTER_SIZE-1];
                w_z = w_z & (w_res[i] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_v1        <= '0;
            r_v2        <= '0;
            r_mask      <= '0;
            r_ovf       <= 1'b0;
            r_br        <= 1'b0;
            r_out_valid <= 1'b0;
            r_vect_out  <= '0;
            r_pc_out    <= 1'b0;
            r_flags     <= 2'b00;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_vect_out  <= w_res;
                r_pc_out    <= w_src_br;
                if (w_src_ovf) r_flags <= {w_z, w_n};
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && (bus.execute_op == 3'(OP_MUL))) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CNT_W'(MUL_CYCLES - 2);
                        r_v1    <= bus.vect1;
                        r_v2    <= bus.vect2;
                        r_mask  <= bus.lane_mask;
                        r_ovf   <= bus.overwrite_flags;
                        r_br    <= w_br_now;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.vect_out     = r_vect_out;
    assign bus.pc_wr_en_out = r_pc_out & r_out_valid;
    assign bus.flags_nz     = r_flags;

endmodule

// File: tb/tb_simd_exec_unit.sv
// Directed bench for simd_exec_unit: ALU ops, masking, flags/branch, MUL
// latency, backpressure and reset during a multiply.
module tb_simd_exec_unit;
    localparam int RS = 32;
    localparam int VS = 4;
    localparam int MC = 4;

    typedef logic [VS-1:0][RS-1:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    simd_exec_unit_if #(.REGISTER_SIZE(RS), .VEC_SIZE(VS)) bus ();

    simd_exec_unit #(.REGISTER_SIZE(RS), .VEC_SIZE(VS), .MUL_CYCLES(MC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t pack(input logic [RS-1:0] l0, input logic [RS-1:0] l1,
                                  input logic [RS-1:0] l2, input logic [RS-1:0] l3);
        vec_t v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [VS-1:0] mask, input logic ovf,
                         input logic [2:0] br, input vec_t a, input vec_t b);
        bus.in_valid        = 1'b1;
        bus.execute_op      = op;
        bus.lane_mask       = mask;
        bus.overwrite_flags = ovf;
        bus.pc_wr_en        = br;
        bus.vect1           = a;
        bus.vect2           = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.execute_op = 3'b000; bus.lane_mask = '0; bus.overwrite_flags = 1'b0;
        bus.pc_wr_en = 3'b000; bus.vect1 = '0; bus.vect2 = '0;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.vect_out !== '0) $display("FAIL rst_vect_out got %h exp 0", bus.vect_out); else n_pass++;
        n_checks++; if (bus.pc_wr_en_out !== 1'b0) $display("FAIL rst_pc got %b exp 0", bus.pc_wr_en_out); else n_pass++;
        n_checks++; if (bus.flags_nz !== 2'b00) $display("FAIL rst_flags got %b exp 00", bus.flags_nz); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_add();
        vec_t exp_v;
        exp_v = pack(32'd11, 32'd22, 32'd33, 32'd44);
        drive(3'b000, 4'b1111, 1'b0, 3'b000, pack(1, 2, 3, 4), pack(10, 20, 30, 40));
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL add_pre_valid got %b exp 0", bus.out_valid); else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b exp 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < VS; i++) begin
            n_checks++;
            if (bus.vect_out[i] !== exp_v[i]) $display("FAIL add_lane%0d got %h exp %h", i, bus.vect_out[i], exp_v[i]);
            else n_pass++;
        end
        n_checks++; if (bus.flags_nz !== 2'b00) $display("FAIL add_flags got %b exp 00", bus.flags_nz); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL add_drain got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    // SUB sets Z, then two back-to-back branch ops read the updated flags.
    task automatic test_back_to_back();
        drive(3'b001, 4'b1111, 1'b1, 3'b000, pack(5, 5, 5, 5), pack(5, 5, 5, 5));
        tick();
        n_checks++; if (bus.vect_out !== '0) $display("FAIL sub_zero got %h exp 0", bus.vect_out); else n_pass++;
        n_checks++; if (bus.flags_nz !== 2'b10) $display("FAIL sub_flags got %b exp 10", bus.flags_nz); else n_pass++;
        drive(3'b000, 4'b1111, 1'b0, 3'b010, pack(1, 1, 1, 1), pack(0, 0, 0, 0));
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.pc_wr_en_out !== 1'b1) $display("FAIL br_z got %b exp 1", bus.pc_wr_en_out); else n_pass++;
        n_checks++; if (bus.vect_out[0] !== 32'd1) $display("FAIL b2b_lane0 got %h exp 1", bus.vect_out[0]); else n_pass++;
        drive(3'b000, 4'b1111, 1'b0, 3'b100, pack(2, 2, 2, 2), pack(0, 0, 0, 0));
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.pc_wr_en_out !== 1'b0) $display("FAIL br_nz got %b exp 0", bus.pc_wr_en_out); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.vect_out[3] !== 32'd2) $display("FAIL b2b_lane3 got %h exp 2", bus.vect_out[3]); else n_pass++;
    endtask

    task automatic test_mask();
        vec_t exp_v;
        // Flags are 10 here, so the N-branch on the first op is not taken.
        drive(3'b001, 4'b0001, 1'b1, 3'b001, pack(0, 7, 8, 9), pack(1, 1, 1, 1));
        tick();
        exp_v = pack(32'hFFFF_FFFF, 32'd7, 32'd8, 32'd9);
        for (int i = 0; i < VS; i++) begin
            n_checks++;
            if (bus.vect_out[i] !== exp_v[i]) $display("FAIL mask1_lane%0d got %h exp %h", i, bus.vect_out[i], exp_v[i]);
            else n_pass++;
        end
        n_checks++; if (bus.flags_nz !== 2'b01) $display("FAIL mask1_flags got %b exp 01", bus.flags_nz); else n_pass++;
        n_checks++; if (bus.pc_wr_en_out !== 1'b0) $display("FAIL mask1_br got %b exp 0", bus.pc_wr_en_out); else n_pass++;
        drive(3'b001, 4'b1110, 1'b1, 3'b001, pack(0, 0, 0, 0), pack(1, 0, 0, 0));
        tick();
        n_checks++; if (bus.vect_out !== '0) $display("FAIL mask2_vect got %h exp 0", bus.vect_out); else n_pass++;
        n_checks++; if (bus.flags_nz !== 2'b10) $display("FAIL mask2_flags got %b exp 10", bus.flags_nz); else n_pass++;
        n_checks++; if (bus.pc_wr_en_out !== 1'b1) $display("FAIL mask2_br got %b exp 1", bus.pc_wr_en_out); else n_pass++;
        drive(3'b001, 4'b0000, 1'b1, 3'b000, pack(32'h8000_0000, 3, 0, 1), pack(0, 3, 0, 0));
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.vect_out[0] !== 32'h8000_0000) $display("FAIL mask0_lane0 got %h exp 80000000", bus.vect_out[0]); else n_pass++;
        n_checks++; if (bus.flags_nz !== 2'b10) $display("FAIL mask0_flags got %b exp 10", bus.flags_nz); else n_pass++;
    endtask

    task automatic test_logic();
        logic [2:0] ops [5];
        vec_t       exp_t [5];
        vec_t       a;
        vec_t       b;
        ops[0] = 3'b010; exp_t[0] = pack(32'h0000_F000, 32'h0000_000F, 32'h0000_0001, 32'h0000_0000);
        ops[1] = 3'b011; exp_t[1] = pack(32'hFFFF_FFF0, 32'h0000_0FFF, 32'h8000_0021, 32'h1234_567C);
        ops[2] = 3'b100; exp_t[2] = pack(32'hFFFF_0FF0, 32'h0000_0FF0, 32'h8000_0020, 32'h1234_567C);
        ops[3] = 3'b101; exp_t[3] = pack(32'hF0F0_F0F0, 32'h007F_8000, 32'h0000_0002, 32'h2345_6780);
        ops[4] = 3'b110; exp_t[4] = pack(32'hF0F0_F0F0, 32'h0000_0000, 32'h4000_0000, 32'h0123_4567);
        a = pack(32'hF0F0_F0F0, 32'h0000_00FF, 32'h8000_0001, 32'h1234_5678);
        b = pack(32'h0F0F_FF00, 32'h0000_0F0F, 32'h0000_0021, 32'h0000_0004);
        for (int k = 0; k < 5; k++) begin
            drive(ops[k], 4'b1111, 1'b0, 3'b000, a, b);
            tick();
            for (int i = 0; i < VS; i++) begin
                n_checks++;
                if (bus.vect_out[i] !== exp_t[k][i])
                    $display("FAIL logic_op%0d_lane%0d got %h exp %h", ops[k], i, bus.vect_out[i], exp_t[k][i]);
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        vec_t exp_v;
        exp_v = pack(32'd15, 32'd0, 32'd0, 32'hFFFF_FFFE);
        drive(3'b111, 4'b1111, 1'b1, 3'b000, pack(3, 32'h10000, 7, 32'hFFFF_FFFF), pack(5, 32'h10000, 0, 2));
        tick();
        bus.in_valid = 1'b0;
        for (int j = 0; j < MC - 1; j++) begin
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL mul_busy%0d_ready got %b exp 0", j, bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mul_busy%0d_valid got %b exp 0", j, bus.out_valid); else n_pass++;
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL mul_valid got %b exp 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < VS; i++) begin
            n_checks++;
            if (bus.vect_out[i] !== exp_v[i]) $display("FAIL mul_lane%0d got %h exp %h", i, bus.vect_out[i], exp_v[i]);
            else n_pass++;
        end
        n_checks++; if (bus.flags_nz !== 2'b01) $display("FAIL mul_flags got %b exp 01", bus.flags_nz); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mul_done_ready got %b exp 1", bus.in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(3'b000, 4'b1111, 1'b0, 3'b000, pack(1, 1, 1, 1), pack(1, 1, 1, 1));
        tick();
        drive(3'b000, 4'b1111, 1'b0, 3'b000, pack(100, 200, 300, 400), pack(0, 0, 0, 0));
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp%0d_ready got %b exp 0", j, bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp%0d_valid got %b exp 1", j, bus.out_valid); else n_pass++;
            n_checks++; if (bus.vect_out !== pack(2, 2, 2, 2)) $display("FAIL bp%0d_hold got %h exp 2s", j, bus.vect_out); else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.vect_out !== pack(100, 200, 300, 400)) $display("FAIL bp_second got %h exp 100..400", bus.vect_out); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_second_valid got %b exp 1", bus.out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        drive(3'b111, 4'b1111, 1'b1, 3'b000, pack(2, 2, 2, 2), pack(3, 3, 3, 3));
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmul_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.flags_nz !== 2'b00) $display("FAIL rmul_flags got %b exp 00", bus.flags_nz); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rmul_ready got %b exp 1", bus.in_ready); else n_pass++;
        for (int j = 0; j < MC + 1; j++) tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmul_stale got %b exp 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.vect_out !== '0) $display("FAIL rmul_vect got %h exp 0", bus.vect_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mask();
        test_logic();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
